alu_pipe: RTL and testbench
===========================

# alu_pipe

Parametrised, handshaked execution-stage ALU with an internal NZCV flag register and an iterative shift-add multiplier. It takes one operation per accepted transfer from the decode/issue stage and returns a registered result to memory/writeback over a valid/ready pair. It replaces the flat combinational ALU in the EXE stage. Flags persist across operations, so carry-using ops (ADC/SBC) chain correctly without external feedback.

## Interface
- WIDTH, 32, datapath width in bits (≥ 8)
- MUL_EN, 1, 1 = MUL command implemented; 0 = MUL treated as undefined
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  operation present
- in_ready  out  1  block can accept; transfer when in_valid && in_ready at a rising edge
- exe_cmd  in  4  operation code
- s_bit  in  1  1 = update flag register with this op's flags
- first  in  WIDTH  operand A (Rn)
- second  in  WIDTH  operand B (shifter operand)
- out_valid  out  1  alu_result valid
- out_ready  in  1  consumer accepts; transfer when out_valid && out_ready
- alu_result  out  WIDTH  registered result
- status  out  4  flag register {Z, C, N, V}

## Operation
- Commands (R = result, Cin = status C): 0001 MOV R=B; 1001 MVN R=~B; 0010 ADD R=A+B; 0011 ADC R=A+B+Cin; 0100 SUB R=A−B; 0101 SBC R=A−B−(1−Cin); 0110 AND; 0111 ORR; 1000 EOR; 1010 MUL R = low WIDTH bits of A×B (unsigned shift-add, one partial product per cycle).
- Other codes (and 1010 when MUL_EN=0): R=0, flags never updated, output still produced.
- Arithmetic is computed at WIDTH+1 bits; C = bit WIDTH of the sum. For SUB/SBC, C = NOT borrow (1 when A ≥ B + borrow, unsigned).
- V: add ops = (A[W-1]==B[W-1]) && (R[W-1]!=A[W-1]); sub ops = (A[W-1]!=B[W-1]) && (R[W-1]!=A[W-1]).
- With s_bit=1: ADD/ADC/SUB/SBC update Z, C, N, V. MOV/MVN/logic/MUL update Z and N only; C and V are held. With s_bit=0, status is unchanged.
- Z = (R==0); N = R[W-1].
- FSM states:
  - IDLE: in_ready = !rst && (!out_valid || out_ready). On accept of a single-cycle op, load R and flags; stay in IDLE. On accept of MUL, latch operands, clear accumulator, counter=0, go to MUL.
  - MUL: in_ready=0. Each cycle, if multiplier LSB is set, accumulator += multiplicand; then multiplicand<<=1 and multiplier>>=1. On the cycle with counter==WIDTH−1, load R and flags, assert out_valid, and go to IDLE.
- Output register holds alu_result and out_valid stable until out_valid && out_ready. Leaving a result with out_ready=0 blocks acceptance (in_ready=0).
- Simultaneous output drain and new accept in IDLE is allowed: the new result overwrites the old one at the same edge.

## Timing
- Reset values: out_valid=0, alu_result=0, status=4'b0000, FSM=IDLE, counter=0; in_ready=0 while rst=1.
- rst asserted mid-MUL aborts the operation: no output is produced and flags are unchanged from their reset value.
- Single-cycle ops: accepted at edge k; alu_result, status, and out_valid=1 are visible after edge k (latency 1).
- Back-to-back issue is possible every cycle with out_ready=1. An op accepted at edge k+1 uses the Cin written at edge k.
- MUL accepted at edge k: result and out_valid appear after edge k+WIDTH. in_ready is low after edges k through k+WIDTH−1.
- status changes only at the edge that loads a result with s_bit=1 (or at reset).

## Test plan
- ADD 0x7FFFFFFF + 0x00000001, s_bit=1 (WIDTH=32) -> alu_result 0x80000000, status 4'b0011, out_valid one cycle after accept.
- SUB 5−5, s_bit=1 -> result 0, status 4'b1100. Then SBC 3−1 (Cin=1) -> result 2, status 4'b0100. Then SBC 3−1 (Cin=0 after SUB 0−1, s_bit=1) -> result 1.
- ADC 0xFFFFFFFF + 0 with prior C=1, s_bit=1 -> result 0, status 4'b1100. Same op with s_bit=0 -> status unchanged.
- MUL 0x00010000 × 0x00010001, s_bit=1 -> result 0x00010000 exactly 32 edges after accept. in_ready stays 0 throughout; C and V are unchanged.
- Backpressure: hold out_ready=0 for 3 cycles after a MOV 0xA5A5A5A5 -> alu_result stable and in_ready=0. The pending op is accepted on the edge where out_ready=1.
- Undefined cmd 4'b1111 with s_bit=1 -> result 0, status unchanged. rst pulsed during MUL -> out_valid stays 0 and status=0.

Source files
------------

// File: rtl/alu_pipe_if.sv
// -----------------------------------------------------------------------------
// alu_pipe_if
// Handshake bundle between the issue stage, the execution-stage ALU and the
// memory/writeback consumer.
//   in_valid / in_ready     : issue-side transfer handshake
//   exe_cmd, s_bit          : operation code and flag-update request
//   first, second           : operands A (Rn) and B (shifter operand)
//   out_valid / out_ready   : result-side transfer handshake
//   alu_result              : registered result word
//   status                  : flag register {Z, C, N, V}
// The master modport is the environment (issue stage + consumer); the slave
// modport is the ALU itself.
// -----------------------------------------------------------------------------
interface alu_pipe_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       exe_cmd;
    logic             s_bit;
    logic [WIDTH-1:0] first;
    logic [WIDTH-1:0] second;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] alu_result;
    logic [3:0]       status;

    modport master (
        output in_valid,
        output exe_cmd,
        output s_bit,
        output first,
        output second,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  alu_result,
        input  status
    );

    modport slave (
        input  in_valid,
        input  exe_cmd,
        input  s_bit,
        input  first,
        input  second,
        input  out_ready,
        output in_ready,
        output out_valid,
        output alu_result,
        output status
    );
endinterface

// File: rtl/alu_pipe.sv
// -----------------------------------------------------------------------------
// alu_pipe
// Handshaked execution-stage ALU with a persistent NZCV flag register and an
// iterative shift-add multiplier (one partial product per clock).
// Ports:
//   clk   : clock, all state changes on the rising edge
//   rst   : synchronous, active-high reset
//   bus   : alu_pipe_if.slave (operation in, result/status out)
// Parameters:
//   WIDTH  : datapath width (>= 8)
//   MUL_EN : 1 implements MUL (4'b1010); 0 treats it as an undefined command
// Single-cycle commands produce their result one edge after acceptance. MUL
// takes WIDTH edges, during which no new operation is accepted.
// -----------------------------------------------------------------------------
module alu_pipe #(
    parameter int WIDTH  = 32,
    parameter bit MUL_EN = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    alu_pipe_if.slave bus
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_MUL = 4'b1010;

    // Bit positions inside the {Z, C, N, V} flag word
    localparam int Z_B = 3;
    localparam int C_B = 2;
    localparam int N_B = 1;
    localparam int V_B = 0;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;

    // Multiplier datapath
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] acc_nx_s;
    logic             mul_sbit_r;
    logic             mul_last_s;

    // Output registers
    logic [WIDTH-1:0] alu_result_r;
    logic             out_valid_r;
    logic [3:0]       status_r;

    // Handshake
    logic             in_ready_s;
    logic             accept_s;
    logic             load_single_s;

    // Single-cycle datapath
    logic             is_sub_s;
    logic             cin_s;
    logic             arith_s;
    logic             zn_only_s;
    logic             is_mul_s;
    logic [WIDTH-1:0] logic_res_s;
    logic [WIDTH-1:0] b_op_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] res_s;
    logic [3:0]       flags_s;

    // Signed overflow of an add (A+B+c) or subtract (A-B-borrow) from the sign bits
    function automatic logic arith_ovf(
        input logic a_msb,
        input logic b_msb,
        input logic r_msb,
        input logic sub
    );
        logic v;
        if (sub) begin
            v = (a_msb != b_msb) && (r_msb != a_msb);
        end else begin
            v = (a_msb == b_msb) && (r_msb != a_msb);
        end
        return v;
    endfunction

    // Flag word for ops that only touch Z and N; C and V carry over from old
    function automatic logic [3:0] zn_flags(
        input logic [3:0]       old,
        input logic [WIDTH-1:0] r
    );
        logic [3:0] f;
        f        = old;
        f[Z_B]   = (r == {WIDTH{1'b0}});
        f[N_B]   = r[WIDTH-1];
        return f;
    endfunction

    // Command decode: operand conditioning, carry-in and flag class
    always_comb begin
        is_sub_s    = 1'b0;
        cin_s       = 1'b0;
        arith_s     = 1'b0;
        zn_only_s   = 1'b0;
        is_mul_s    = 1'b0;
        logic_res_s = {WIDTH{1'b0}};
        case (bus.exe_cmd)
            CMD_MOV: begin
                logic_res_s = bus.second;
                zn_only_s   = 1'b1;
            end
            CMD_MVN: begin
                logic_res_s = ~bus.second;
                zn_only_s   = 1'b1;
            end
            CMD_ADD: begin
                arith_s = 1'b1;
            end
            CMD_ADC: begin
                arith_s = 1'b1;
                cin_s   = status_r[C_B];
            end
            // A - B computed as A + ~B + 1 so the adder carry-out is NOT borrow
            CMD_SUB: begin
                arith_s  = 1'b1;
                is_sub_s = 1'b1;
                cin_s    = 1'b1;
            end
            // A - B - (1 - C) == A + ~B + C
            CMD_SBC: begin
                arith_s  = 1'b1;
                is_sub_s = 1'b1;
                cin_s    = status_r[C_B];
            end
            CMD_AND: begin
                logic_res_s = bus.first & bus.second;
                zn_only_s   = 1'b1;
            end
            CMD_ORR: begin
                logic_res_s = bus.first | bus.second;
                zn_only_s   = 1'b1;
            end
            CMD_EOR: begin
                logic_res_s = bus.first ^ bus.second;
                zn_only_s   = 1'b1;
            end
            CMD_MUL: begin
                if (MUL_EN) begin
                    is_mul_s = 1'b1;
                end else begin
                    is_mul_s = 1'b0;
                end
            end
            default: begin
                is_mul_s = 1'b0;
            end
        endcase
    end

    assign b_op_s = is_sub_s ? ~bus.second : bus.second;
    assign sum_s  = {1'b0, bus.first} + {1'b0, b_op_s} + {{WIDTH{1'b0}}, cin_s};

    // Single-cycle result and the flag word it would write; undefined codes give 0 and keep flags
    always_comb begin
        res_s   = {WIDTH{1'b0}};
        flags_s = status_r;
        if (arith_s) begin
            res_s          = sum_s[WIDTH-1:0];
            flags_s[Z_B]   = (sum_s[WIDTH-1:0] == {WIDTH{1'b0}});
            flags_s[C_B]   = sum_s[WIDTH];
            flags_s[N_B]   = sum_s[WIDTH-1];
            flags_s[V_B]   = arith_ovf(bus.first[WIDTH-1], bus.second[WIDTH-1],
                                       sum_s[WIDTH-1], is_sub_s);
        end else if (zn_only_s) begin
            res_s   = logic_res_s;
            flags_s = zn_flags(status_r, logic_res_s);
        end else begin
            res_s   = {WIDTH{1'b0}};
            flags_s = status_r;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next state and input-side ready
    always_comb begin
        state_nx_s = state_r;
        in_ready_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                // A pending result that is not being drained this cycle blocks issue
                in_ready_s = !rst && (!out_valid_r || bus.out_ready);
                if (in_ready_s && bus.in_valid && is_mul_s) begin
                    state_nx_s = ST_MUL;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_MUL: begin
                in_ready_s = 1'b0;
                if (mul_last_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_MUL;
                end
            end
            default: begin
                in_ready_s = 1'b0;
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    assign accept_s      = in_ready_s && bus.in_valid;
    assign load_single_s = accept_s && !is_mul_s;
    assign mul_last_s    = (state_r == ST_MUL) && (cnt_r == CNT_W'(WIDTH - 1));
    // Accumulator value after the current partial product; on the last step this is the product
    assign acc_nx_s      = mplier_r[0] ? (acc_r + mcand_r) : acc_r;

    // Shift-add multiplier operand, accumulator and step counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r      <= {CNT_W{1'b0}};
            mcand_r    <= {WIDTH{1'b0}};
            mplier_r   <= {WIDTH{1'b0}};
            acc_r      <= {WIDTH{1'b0}};
            mul_sbit_r <= 1'b0;
        end else if (accept_s && is_mul_s) begin
            cnt_r      <= {CNT_W{1'b0}};
            mcand_r    <= bus.first;
            mplier_r   <= bus.second;
            acc_r      <= {WIDTH{1'b0}};
            mul_sbit_r <= bus.s_bit;
        end else if (state_r == ST_MUL) begin
            acc_r    <= acc_nx_s;
            mcand_r  <= {mcand_r[WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            cnt_r    <= mul_last_s ? {CNT_W{1'b0}} : (cnt_r + CNT_W'(1));
        end
    end

    // Result, valid and flag registers; a new load wins over a drain at the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_result_r <= {WIDTH{1'b0}};
            out_valid_r  <= 1'b0;
            status_r     <= 4'b0000;
        end else if (load_single_s) begin
            alu_result_r <= res_s;
            out_valid_r  <= 1'b1;
            if (bus.s_bit) begin
                status_r <= flags_s;
            end
        end else if (mul_last_s) begin
            alu_result_r <= acc_nx_s;
            out_valid_r  <= 1'b1;
            if (mul_sbit_r) begin
                status_r <= zn_flags(status_r, acc_nx_s);
            end
        end else if (out_valid_r && bus.out_ready) begin
            out_valid_r <= 1'b0;
        end
    end

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.alu_result = alu_result_r;
    assign bus.status     = status_r;

endmodule

// File: tb/tb_alu_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu_pipe
// Self-checking bench for alu_pipe (WIDTH=32, MUL_EN=1). Expected values come
// from a reference model that evaluates each command with 64-bit integer
// arithmetic and tracks the {Z, C, N, V} flag word.
// -----------------------------------------------------------------------------
module tb_alu_pipe;

    localparam int WIDTH = 32;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(WIDTH)) bus ();

    alu_pipe #(.WIDTH(WIDTH), .MUL_EN(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [3:0] m_status;

    // Count one comparison and report it when observed and expected differ
    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model: result of one command and its effect on the flag word
    task automatic ref_op(input logic [3:0] cmd, input logic s, input logic [31:0] a,
                          input logic [31:0] b, output logic [31:0] r);
        longint unsigned ua, ub, full;
        longint          sa, sb, sr, ci, bw;
        logic            c, v;
        int              kind;   // 0: no flags, 1: Z/N only, 2: Z/C/N/V
        ua = a; ub = b;
        sa = $signed(a); sb = $signed(b);
        ci = m_status[2] ? 64'sd1 : 64'sd0;
        bw = 64'sd1 - ci;
        c = 1'b0; v = 1'b0; kind = 0; full = 0; sr = 0; r = 32'd0;
        case (cmd)
            4'd1:  begin r = b;      kind = 1; end
            4'd9:  begin r = ~b;     kind = 1; end
            4'd6:  begin r = a & b;  kind = 1; end
            4'd7:  begin r = a | b;  kind = 1; end
            4'd8:  begin r = a ^ b;  kind = 1; end
            4'd10: begin full = ua * ub; r = full[31:0]; kind = 1; end
            4'd2:  begin full = ua + ub;      r = full[31:0]; c = full[32]; sr = sa + sb;      kind = 2; end
            4'd3:  begin full = ua + ub + ci; r = full[31:0]; c = full[32]; sr = sa + sb + ci; kind = 2; end
            4'd4:  begin r = a - b; c = (ua >= ub); sr = sa - sb; kind = 2; end
            4'd5:  begin full = ua - ub - bw; r = full[31:0]; c = (ua >= ub + bw); sr = sa - sb - bw; kind = 2; end
            default: begin r = 32'd0; kind = 0; end
        endcase
        if (kind == 2) v = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        if (s && kind == 2)      m_status = {(r == 32'd0), c, r[31], v};
        else if (s && kind == 1) m_status = {(r == 32'd0), m_status[2], r[31], m_status[0]};
    endtask

    // Issue one operation with out_ready=1, wait for its result and check it against the model
    task automatic do_op(input logic [3:0] cmd, input logic s, input logic [31:0] a,
                         input logic [31:0] b, output logic [31:0] r);
        int n;
        int e;
        bus.exe_cmd = cmd; bus.s_bit = s; bus.first = a; bus.second = b;
        bus.in_valid = 1'b1;
        #1;
        n = 0;
        while (bus.in_ready !== 1'b1 && n < 200) begin
            step();
            n++;
        end
        check_val("accept_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        ref_op(cmd, s, a, b, r);
        if (cmd == 4'd10) begin
            e = 0;
            while (bus.out_valid !== 1'b1 && e < WIDTH + 4) begin
                check_val("mul_busy_ready", 64'(bus.in_ready), 64'd0);
                step();
                e++;
            end
            check_val("mul_latency", 64'(e), 64'(WIDTH));
        end
        check_val("op_valid",  64'(bus.out_valid),  64'd1);
        check_val("op_result", 64'(bus.alu_result), 64'(r));
        check_val("op_status", 64'(bus.status),     64'(m_status));
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h8000_0000;
            default: return 32'($urandom());
        endcase
    endfunction

    function automatic logic [3:0] rand_cmd(input bit with_mul);
        logic [3:0] c;
        c = 4'($urandom_range(0, 15));
        if (!with_mul && c == 4'd10) c = 4'd3;
        return c;
    endfunction

    initial begin
        logic [31:0] r;
        logic [31:0] a, b;
        logic [3:0]  cmd;
        logic        s;
        logic [3:0]  st_before;
        int          bad;

        rst = 1'b1;
        bus.in_valid = 1'b0; bus.exe_cmd = 4'd0; bus.s_bit = 1'b0;
        bus.first = 32'd0; bus.second = 32'd0; bus.out_ready = 1'b1;
        m_status = 4'b0000;

        // Reset state
        repeat (3) begin
            step();
            check_val("rst_in_ready", 64'(bus.in_ready), 64'd0);
        end
        rst = 1'b0;
        check_val("rst_out_valid", 64'(bus.out_valid),  64'd0);
        check_val("rst_result",    64'(bus.alu_result), 64'd0);
        check_val("rst_status",    64'(bus.status),     64'd0);

        // Directed arithmetic and flag chaining
        do_op(4'd2, 1'b1, 32'h7FFF_FFFF, 32'h0000_0001, r);
        check_val("add_ovf_res", 64'(bus.alu_result), 64'h8000_0000);
        check_val("add_ovf_st",  64'(bus.status),     64'b0011);
        do_op(4'd4, 1'b1, 32'd5, 32'd5, r);
        check_val("sub_eq_st", 64'(bus.status), 64'b1100);
        do_op(4'd5, 1'b1, 32'd3, 32'd1, r);
        check_val("sbc_c1_res", 64'(bus.alu_result), 64'd2);
        check_val("sbc_c1_st",  64'(bus.status),     64'b0100);
        do_op(4'd4, 1'b1, 32'd0, 32'd1, r);
        do_op(4'd5, 1'b1, 32'd3, 32'd1, r);
        check_val("sbc_c0_res", 64'(bus.alu_result), 64'd1);
        do_op(4'd4, 1'b1, 32'd5, 32'd5, r);
        do_op(4'd3, 1'b1, 32'hFFFF_FFFF, 32'd0, r);
        check_val("adc_res", 64'(bus.alu_result), 64'd0);
        check_val("adc_st",  64'(bus.status),     64'b1100);
        do_op(4'd2, 1'b0, 32'h7FFF_FFFF, 32'd1, r);
        check_val("nos_st", 64'(bus.status), 64'b1100);

        // MUL holds C and V: set both first
        do_op(4'd2, 1'b1, 32'hFFFF_FFFF, 32'h8000_0000, r);
        check_val("pre_mul_st", 64'(bus.status), 64'b0101);
        do_op(4'd10, 1'b1, 32'h0001_0000, 32'h0001_0001, r);
        check_val("mul_res", 64'(bus.alu_result), 64'h0001_0000);
        check_val("mul_st",  64'(bus.status),     64'b0101);

        // Undefined command
        do_op(4'd15, 1'b1, 32'h1234_5678, 32'h0000_5678, r);
        check_val("undef_res", 64'(bus.alu_result), 64'd0);
        check_val("undef_st",  64'(bus.status),     64'b0101);

        // Backpressure: drain, then hold a MOV result with out_ready low
        step();
        bus.out_ready = 1'b0;
        do_op(4'd1, 1'b0, 32'd0, 32'hA5A5_A5A5, r);
        bus.exe_cmd = 4'd2; bus.s_bit = 1'b0; bus.first = 32'd1; bus.second = 32'd2;
        bus.in_valid = 1'b1;
        repeat (3) begin
            #1;
            check_val("bp_in_ready", 64'(bus.in_ready),   64'd0);
            check_val("bp_valid",    64'(bus.out_valid),  64'd1);
            check_val("bp_result",   64'(bus.alu_result), 64'hA5A5_A5A5);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        check_val("bp_release_ready", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        ref_op(4'd2, 1'b0, 32'd1, 32'd2, r);
        check_val("bp_new_result", 64'(bus.alu_result), 64'(r));
        check_val("bp_new_valid",  64'(bus.out_valid),  64'd1);
        step();
        check_val("bp_drained", 64'(bus.out_valid), 64'd0);

        // Back-to-back random single-cycle issue; each op sees the previous op's carry
        for (int i = 0; i < 300; i++) begin
            cmd = rand_cmd(1'b0);
            s   = 1'($urandom_range(0, 1));
            a   = rand_operand();
            b   = rand_operand();
            bus.exe_cmd = cmd; bus.s_bit = s; bus.first = a; bus.second = b;
            bus.in_valid = 1'b1;
            #1;
            check_val("b2b_ready", 64'(bus.in_ready), 64'd1);
            step();
            ref_op(cmd, s, a, b, r);
            check_val("b2b_valid",  64'(bus.out_valid),  64'd1);
            check_val("b2b_result", 64'(bus.alu_result), 64'(r));
            check_val("b2b_status", 64'(bus.status),     64'(m_status));
        end
        bus.in_valid = 1'b0;

        // Random mix including multiplies
        for (int i = 0; i < 24; i++) begin
            cmd = (i % 3 == 0) ? 4'd10 : rand_cmd(1'b1);
            do_op(cmd, 1'($urandom_range(0, 1)), rand_operand(), rand_operand(), r);
        end

        // Make the flag word non-zero, then abort a MUL with reset
        do_op(4'd4, 1'b1, 32'd0, 32'd1, r);
        st_before = m_status;
        check_val("pre_abort_st", 64'(bus.status), 64'(st_before));
        bus.exe_cmd = 4'd10; bus.s_bit = 1'b1;
        bus.first = 32'h0000_0003; bus.second = 32'h0000_0005;
        bus.in_valid = 1'b1;
        #1;
        check_val("abort_accept", 64'(bus.in_ready), 64'd1);
        step();
        bus.in_valid = 1'b0;
        repeat (5) step();
        check_val("abort_busy", 64'(bus.in_ready), 64'd0);
        rst = 1'b1;
        #1;
        check_val("abort_rst_ready", 64'(bus.in_ready), 64'd0);
        step();
        rst = 1'b0;
        m_status = 4'b0000;
        check_val("abort_valid",  64'(bus.out_valid),  64'd0);
        check_val("abort_status", 64'(bus.status),     64'd0);
        check_val("abort_result", 64'(bus.alu_result), 64'd0);
        bad = 0;
        repeat (WIDTH + 4) begin
            step();
            if (bus.out_valid !== 1'b0) bad++;
        end
        check_val("abort_no_output", 64'(bad), 64'd0);

        // Operation after the aborted multiply
        do_op(4'd2, 1'b1, 32'd1, 32'd2, r);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
